// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// Captures the decode control bundle, operands, immediate and register
// specifiers for the EX stage. When an EX-stage load writes a register that
// the ID-stage instruction reads, one bubble is inserted into EX and the PC
// and IF/ID stages are stalled. A saturating counter records the number of
// load-use bubbles for performance debug.
//
// Slot semantics: ex_valid_o marks a real instruction in EX. It is updated on
// every rising edge that is not frozen by hold_i. There is no backpressure
// path other than stall_o (a request to upstream to hold) and hold_i (a
// global freeze of this register).
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [9:0]        id_ctrl_i,
  input  logic [RA_W-1:0]   id_rs_i,
  input  logic [RA_W-1:0]   id_rt_i,
  input  logic [RA_W-1:0]   id_rd_i,
  input  logic [DATA_W-1:0] id_rdata1_i,
  input  logic [DATA_W-1:0] id_rdata2_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [DATA_W-1:0] id_pc4_i,
  input  logic [5:0]        id_funct_i,
  output logic              ex_valid_o,
  output logic [9:0]        ex_ctrl_o,
  output logic [RA_W-1:0]   ex_rs_o,
  output logic [RA_W-1:0]   ex_rt_o,
  output logic [RA_W-1:0]   ex_rd_o,
  output logic [DATA_W-1:0] ex_rdata1_o,
  output logic [DATA_W-1:0] ex_rdata2_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [DATA_W-1:0] ex_pc4_o,
  output logic [5:0]        ex_funct_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  // Bit positions inside the control bundle:
  // {RegWrite,Branch,RegDst,MemRead,MemWrite,MemtoReg,ALUSrc,Jump,ALUop[1:0]}
  localparam int CTRL_REGWRITE = 9;
  localparam int CTRL_BRANCH   = 8;
  localparam int CTRL_REGDST   = 7;
  localparam int CTRL_MEMREAD  = 6;
  localparam int CTRL_MEMWRITE = 5;
  localparam int CTRL_MEMTOREG = 4;
  localparam int CTRL_ALUSRC   = 3;
  localparam int CTRL_JUMP     = 2;

  logic             luse;
  logic             rt_nonzero;
  logic             rt_hit;
  logic             cnt_full;
  logic [9:0]       ctrl_load;

  // Load-use detection: an EX load whose destination (rt, never $0) matches
  // either source of the ID instruction.
  always_comb begin
    rt_nonzero = (ex_rt_o != '0);
    rt_hit     = (ex_rt_o == id_rs_i) | (ex_rt_o == id_rt_i);
    luse       = ex_valid_o & ex_ctrl_o[CTRL_MEMREAD] & id_valid_i
                 & rt_nonzero & rt_hit;
    // A flush kills the ID instruction anyway; under hold upstream is
    // already frozen, so no stall is requested in either case.
    stall_o    = luse & ~flush_i & ~hold_i;
    cnt_full   = &bubble_cnt_o;
    // An empty slot must never carry control bits into EX.
    ctrl_load  = id_valid_i ? id_ctrl_i : 10'b0;
  end

  // Pipeline register: hold > flush > load-use bubble > normal load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_o  <= 1'b0;
      ex_ctrl_o   <= '0;
      ex_rs_o     <= '0;
      ex_rt_o     <= '0;
      ex_rd_o     <= '0;
      ex_rdata1_o <= '0;
      ex_rdata2_o <= '0;
      ex_imm_o    <= '0;
      ex_pc4_o    <= '0;
      ex_funct_o  <= '0;
    end else if (!hold_i) begin
      // Data fields load in every non-held cycle; in a bubble they are
      // don't-care for EX but stay deterministic.
      ex_rs_o     <= id_rs_i;
      ex_rt_o     <= id_rt_i;
      ex_rd_o     <= id_rd_i;
      ex_rdata1_o <= id_rdata1_i;
      ex_rdata2_o <= id_rdata2_i;
      ex_imm_o    <= id_imm_i;
      ex_pc4_o    <= id_pc4_i;
      ex_funct_o  <= id_funct_i;
      if (flush_i || luse) begin
        ex_valid_o <= 1'b0;
        ex_ctrl_o  <= '0;
      end else begin
        ex_valid_o <= id_valid_i;
        ex_ctrl_o  <= ctrl_load;
      end
    end
  end

  // Bubble counter: counts load-use bubbles only, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_o <= '0;
    end else if (!hold_i && !flush_i && luse && !cnt_full) begin
      bubble_cnt_o <= bubble_cnt_o + 1'b1;
    end
  end

  // Named control fields, kept for readability of the bundle layout; the
  // register itself passes the whole bundle through untouched.
  logic unused_ctrl_fields;
  always_comb begin
    unused_ctrl_fields = ex_ctrl_o[CTRL_REGWRITE] ^ ex_ctrl_o[CTRL_BRANCH]
                       ^ ex_ctrl_o[CTRL_REGDST] ^ ex_ctrl_o[CTRL_MEMWRITE]
                       ^ ex_ctrl_o[CTRL_MEMTOREG] ^ ex_ctrl_o[CTRL_ALUSRC]
                       ^ ex_ctrl_o[CTRL_JUMP];
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg. The driver applies one directed vector per cycle
// with hand-computed expected EX contents; a monitor compares each pushed
// expectation against the registered outputs on the following falling edge.
module tb_id_ex_pipe_reg;

  localparam int DATA_W = 32;
  localparam int RA_W   = 5;
  localparam int CNT_W  = 4;
  localparam int EXP_W  = 1 + 10 + 3*RA_W + DATA_W + CNT_W;

  localparam logic [9:0] C_R  = 10'b1010000010;
  localparam logic [9:0] C_LW = 10'b1001011000;

  logic              clk;
  logic              rst_n;
  logic              hold_i;
  logic              flush_i;
  logic              id_valid_i;
  logic [9:0]        id_ctrl_i;
  logic [RA_W-1:0]   id_rs_i;
  logic [RA_W-1:0]   id_rt_i;
  logic [RA_W-1:0]   id_rd_i;
  logic [DATA_W-1:0] id_rdata1_i;
  logic [DATA_W-1:0] id_rdata2_i;
  logic [DATA_W-1:0] id_imm_i;
  logic [DATA_W-1:0] id_pc4_i;
  logic [5:0]        id_funct_i;
  logic              ex_valid_o;
  logic [9:0]        ex_ctrl_o;
  logic [RA_W-1:0]   ex_rs_o;
  logic [RA_W-1:0]   ex_rt_o;
  logic [RA_W-1:0]   ex_rd_o;
  logic [DATA_W-1:0] ex_rdata1_o;
  logic [DATA_W-1:0] ex_rdata2_o;
  logic [DATA_W-1:0] ex_imm_o;
  logic [DATA_W-1:0] ex_pc4_o;
  logic [5:0]        ex_funct_o;
  logic              stall_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  logic [EXP_W-1:0] exp_q[$];
  int total;
  int bad;
  int exp_cnt;

  id_ex_pipe_reg #(.DATA_W(DATA_W), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .hold_i(hold_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_ctrl_i(id_ctrl_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
    .id_rdata1_i(id_rdata1_i), .id_rdata2_i(id_rdata2_i),
    .id_imm_i(id_imm_i), .id_pc4_i(id_pc4_i), .id_funct_i(id_funct_i),
    .ex_valid_o(ex_valid_o), .ex_ctrl_o(ex_ctrl_o),
    .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o),
    .ex_rdata1_o(ex_rdata1_o), .ex_rdata2_o(ex_rdata2_o),
    .ex_imm_o(ex_imm_o), .ex_pc4_o(ex_pc4_o), .ex_funct_o(ex_funct_o),
    .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one ID vector (caller is at a falling edge), check the
  // combinational stall, queue the expected EX contents, advance one cycle.
  // Data inputs derive from d: rdata2=d^0x33, imm=d+2, pc4=d+4, funct=d[5:0].
  task automatic vec(input logic v, input logic [9:0] c,
                     input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                     input logic [31:0] d, input logic h, input logic f,
                     input logic es, input logic ev, input logic [9:0] ec,
                     input logic [4:0] ers, input logic [4:0] ert, input logic [4:0] erd,
                     input logic [31:0] ed, input logic [3:0] ecnt);
    id_valid_i  = v;
    id_ctrl_i   = c;
    id_rs_i     = rs;
    id_rt_i     = rt;
    id_rd_i     = rd;
    id_rdata1_i = d;
    id_rdata2_i = d ^ 32'h33;
    id_imm_i    = d + 32'd2;
    id_pc4_i    = d + 32'd4;
    id_funct_i  = d[5:0];
    hold_i      = h;
    flush_i     = f;
    #1;
    chk("stall", {31'b0, stall_o}, {31'b0, es});
    exp_q.push_back({ev, ec, ers, ert, erd, ed, ecnt});
    @(negedge clk);
  endtask

  // Monitor / scoreboard: one expectation per cycle after the edge.
  initial begin
    logic [EXP_W-1:0] e;
    logic [31:0] ed;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        ed = e[35:4];
        chk("ex_valid",  {31'b0, ex_valid_o}, {31'b0, e[61]});
        chk("ex_ctrl",   {22'b0, ex_ctrl_o},  {22'b0, e[60:51]});
        chk("ex_rs",     {27'b0, ex_rs_o},    {27'b0, e[50:46]});
        chk("ex_rt",     {27'b0, ex_rt_o},    {27'b0, e[45:41]});
        chk("ex_rd",     {27'b0, ex_rd_o},    {27'b0, e[40:36]});
        chk("ex_rdata1", ex_rdata1_o, ed);
        chk("ex_rdata2", ex_rdata2_o, ed ^ 32'h33);
        chk("ex_imm",    ex_imm_o,    ed + 32'd2);
        chk("ex_pc4",    ex_pc4_o,    ed + 32'd4);
        chk("ex_funct",  {26'b0, ex_funct_o}, {26'b0, ed[5:0]});
        chk("bubble_cnt", {28'b0, bubble_cnt_o}, {28'b0, e[3:0]});
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, {31'b0, ex_valid_o}, 32'd0);
    chk({tag, "_ctrl"},  {22'b0, ex_ctrl_o}, 32'd0);
    chk({tag, "_specs"}, {17'b0, ex_rs_o, ex_rt_o, ex_rd_o}, 32'd0);
    chk({tag, "_rdata1"}, ex_rdata1_o, 32'd0);
    chk({tag, "_rdata2"}, ex_rdata2_o, 32'd0);
    chk({tag, "_imm"},    ex_imm_o, 32'd0);
    chk({tag, "_pc4"},    ex_pc4_o, 32'd0);
    chk({tag, "_funct"},  {26'b0, ex_funct_o}, 32'd0);
    chk({tag, "_stall"},  {31'b0, stall_o}, 32'd0);
    chk({tag, "_cnt"},    {28'b0, bubble_cnt_o}, 32'd0);
  endtask

  // Stimulus
  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    hold_i = 1'b0; flush_i = 1'b0; id_valid_i = 1'b0; id_ctrl_i = '0;
    id_rs_i = '0; id_rt_i = '0; id_rd_i = '0;
    id_rdata1_i = '0; id_rdata2_i = '0; id_imm_i = '0; id_pc4_i = '0; id_funct_i = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // reset and load
    vec(1, C_R, 1, 2, 3, 'h11, 0, 0,  0, 1, C_R, 1, 2, 3, 'h11, 0);
    // load-use on rs
    vec(1, C_LW, 2, 5, 0, 'h40, 0, 0,  0, 1, C_LW, 2, 5, 0, 'h40, 0);
    vec(1, C_R, 5, 8, 9, 'h50, 0, 0,   1, 0, 10'b0, 5, 8, 9, 'h50, 1);
    vec(1, C_R, 5, 8, 9, 'h50, 0, 0,   0, 1, C_R, 5, 8, 9, 'h50, 1);
    // no hazard: rt=0
    vec(1, C_LW, 3, 0, 0, 'h60, 0, 0,  0, 1, C_LW, 3, 0, 0, 'h60, 1);
    vec(1, C_R, 0, 4, 6, 'h61, 0, 0,   0, 1, C_R, 0, 4, 6, 'h61, 1);
    // no hazard: specifiers differ
    vec(1, C_LW, 1, 5, 0, 'h70, 0, 0,  0, 1, C_LW, 1, 5, 0, 'h70, 1);
    vec(1, C_R, 6, 7, 2, 'h71, 0, 0,   0, 1, C_R, 6, 7, 2, 'h71, 1);
    // flush overrides a live load-use
    vec(1, C_LW, 1, 5, 0, 'h80, 0, 0,  0, 1, C_LW, 1, 5, 0, 'h80, 1);
    vec(1, C_R, 5, 1, 4, 'h81, 0, 1,   0, 0, 10'b0, 5, 1, 4, 'h81, 1);
    // invalid slot carries no control
    vec(0, C_R, 5, 2, 3, 'h90, 0, 0,   0, 0, 10'b0, 5, 2, 3, 'h90, 1);
    // hold for three cycles with a live hazard and changing inputs
    vec(1, C_LW, 1, 7, 0, 'hA0, 0, 0,  0, 1, C_LW, 1, 7, 0, 'hA0, 1);
    vec(1, C_R, 7, 3, 4, 'hB0, 1, 0,   0, 1, C_LW, 1, 7, 0, 'hA0, 1);
    vec(1, C_R, 7, 3, 4, 'hB1, 1, 0,   0, 1, C_LW, 1, 7, 0, 'hA0, 1);
    vec(1, C_R, 7, 3, 4, 'hB2, 1, 0,   0, 1, C_LW, 1, 7, 0, 'hA0, 1);
    vec(1, C_R, 7, 3, 4, 'hB3, 0, 0,   1, 0, 10'b0, 7, 3, 4, 'hB3, 2);
    vec(1, C_R, 7, 3, 4, 'hB3, 0, 0,   0, 1, C_R, 7, 3, 4, 'hB3, 2);
    // load-use on rt
    vec(1, C_LW, 1, 9, 0, 'hB8, 0, 0,  0, 1, C_LW, 1, 9, 0, 'hB8, 2);
    vec(1, C_R, 2, 9, 4, 'hB9, 0, 0,   1, 0, 10'b0, 2, 9, 4, 'hB9, 3);

    // saturation: 20 load-use events, counter must stop at 15
    exp_cnt = 3;
    for (int i = 0; i < 20; i++) begin
      vec(1, C_LW, 1, 5, 0, 32'hC0 + i, 0, 0,  0, 1, C_LW, 1, 5, 0, 32'hC0 + i, exp_cnt[3:0]);
      exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
      vec(1, C_R, 5, 6, 7, 32'hE0 + i, 0, 0,   1, 0, 10'b0, 5, 6, 7, 32'hE0 + i, exp_cnt[3:0]);
    end
    chk("cnt_saturated", {28'b0, bubble_cnt_o}, 32'd15);

    // asynchronous reset between edges
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    vec(1, C_R, 1, 2, 3, 'h11, 0, 0,  0, 1, C_R, 1, 2, 3, 'h11, 0);

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register sitting directly downstream of the decode-stage control unit.
- Captures the decode control bundle (RegWrite, Branch, RegDst, MemRead, MemWrite, MemtoReg, ALUSrc, Jump, ALUop), register operands, immediate and register specifiers for the EX stage.
- Contains the load-use hazard detector: it inserts a bubble into EX and raises a stall to the PC and IF/ID stages.
- Keeps a saturating bubble counter for performance debug.

Parameters:
DATA_W, 32, width of operand, immediate and PC+4 fields
RA_W, 5, register specifier width
CNT_W, 16, bubble counter width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
hold_i  in  1  global freeze (memory stall); register keeps its contents
flush_i  in  1  taken branch/jump from EX; kill the instruction entering EX
id_valid_i  in  1  IF/ID holds a real instruction
id_ctrl_i  in  10  {RegWrite,Branch,RegDst,MemRead,MemWrite,MemtoReg,ALUSrc,Jump,ALUop[1:0]}
id_rs_i  in  RA_W  rs field
id_rt_i  in  RA_W  rt field
id_rd_i  in  RA_W  rd field
id_rdata1_i  in  DATA_W  register file port 1
id_rdata2_i  in  DATA_W  register file port 2
id_imm_i  in  DATA_W  sign-extended immediate
id_pc4_i  in  DATA_W  PC+4
id_funct_i  in  6  funct field
ex_valid_o  out  1  EX holds a real instruction
ex_ctrl_o  out  10  registered control bundle, same packing as id_ctrl_i
ex_rs_o, ex_rt_o, ex_rd_o  out  RA_W  registered specifiers
ex_rdata1_o, ex_rdata2_o, ex_imm_o, ex_pc4_o  out  DATA_W  registered data
ex_funct_o  out  6  registered funct
stall_o  out  1  combinational; hold PC and IF/ID this cycle
bubble_cnt_o  out  CNT_W  bubbles inserted since reset, saturating

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs and registers clear to 0: ex_valid_o=0, ex_ctrl_o=0, all data and specifiers 0, bubble_cnt_o=0.
  - Reset asserted mid-operation discards the in-flight instruction immediately, without waiting for a clock edge.
- Load-use detection is combinational: luse = ex_valid_o & ex_ctrl_o[MemRead] & id_valid_i & (ex_rt_o != 0) & ((ex_rt_o == id_rs_i) | (ex_rt_o == id_rt_i)).
- stall_o = luse & ~flush_i & ~hold_i.
  - A flush overrides the stall because the ID instruction is being killed.
  - Under hold_i, upstream is frozen by hold_i itself, so stall_o stays low.
- Per rising edge, priority high to low:
  1. hold_i=1: all registers keep their value and the counter does not change.
  2. flush_i=1: bubble. ex_valid_o<=0, ex_ctrl_o<=0. Data fields load from inputs; they are don't-care but are loaded deterministically. The counter does not increment.
  3. luse=1: bubble as above and bubble_cnt_o increments.
  4. Otherwise: load every field from the id_* inputs; ex_valid_o<=id_valid_i.
     - If id_valid_i=0, ex_ctrl_o<=0, so no X control values from an undefined opcode reach EX when the slot is invalid.
- Latency is 1 cycle from ID inputs to EX outputs. A load-use hazard costs exactly one bubble: after the bubble, ex_valid_o=0, so luse drops and the held ID instruction advances on the next edge.
- Counter: it increments by 1 per load-use bubble and saturates at all-ones (no wrap).
- ex_ctrl_o bits that the control unit drives as X for valid opcodes are passed through unchanged. EX must treat them as don't-care.
- Register $0: ex_rt_o==0 never triggers a hazard.

Test Plan:
1. Reset and load:
   - Stimulus: rst_n low; release; drive a valid R-type with ctrl=10'b1010000010, rs=1, rt=2, rd=3, rdata1=0x11, rdata2=0x22.
   - Required: all outputs 0 during reset. One edge after release, ex_ctrl_o=10'b1010000010, ex_rdata1_o=0x11, ex_rd_o=3, ex_valid_o=1.
2. Load-use hazard:
   - Stimulus: load LW (MemRead=1, rt=5) into EX; next ID has rs=5.
   - Required: stall_o=1 that cycle. Next edge gives ex_valid_o=0 and ex_ctrl_o=0, and bubble_cnt_o=1. On the following edge the held instruction loads and stall_o=0.
3. No hazard cases:
   - Stimulus: LW in EX with rt=0 and ID rs=0; separately, LW rt=5 in EX with ID rs=6, rt=7.
   - Required: stall_o=0 and the counter stays unchanged in both cases.
4. Flush priority:
   - Stimulus: assert flush_i together with a live load-use condition.
   - Required: stall_o=0, a bubble is inserted, and bubble_cnt_o does not increment.
5. Hold:
   - Stimulus: assert hold_i for 3 cycles while the ID inputs change.
   - Required: EX outputs and the counter stay frozen and stall_o=0. The load resumes on the first edge after hold_i falls.
6. Counter saturation and async reset:
   - Stimulus: preload the counter near max with CNT_W=4; create 20 load-use events; then pulse rst_n low between clock edges.
   - Required: bubble_cnt_o stops at 15. During the rst_n pulse, all outputs clear immediately.
